eth_rx_pkt_fifo: RTL

//  Store-and-forward RX frame buffer between the 10G MAC RX AXI-Stream master and the encap stage.
//  MAC RX has no tready; this block absorbs frames and supplies a tready-capable AXIS master.

---
 rtl/eth_rx_pkt_fifo.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/eth_rx_pkt_fifo.sv
// Store-and-forward RX frame buffer. It absorbs MAC RX beats, which have no backpressure, and
// forwards only complete, good frames on a tready-capable AXI-Stream master.
`timescale 1ns/1ps
module eth_rx_pkt_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk156,
  input  logic                  eth_rst,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [31:0]           frame_cnt,
  output logic [15:0]           drop_err_cnt,
  output logic [15:0]           drop_ovf_cnt
);

  localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
  localparam int unsigned WORD_W = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic {ST_WR = 1'b0, ST_DROP = 1'b1} wr_state_e;

  wr_state_e         state, state_nxt;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_inc;
  logic              full;
  logic              wr_en, do_commit, do_rewind, inc_err, inc_ovf;
  logic [WORD_W-1:0] ram_q;
  logic              ram_vld;
  logic              rd_en, out_load;

  // One slot is always kept spare, so full can never look like empty.
  assign wr_ptr_inc = wr_ptr + PTR_W'(1);
  assign full       = (wr_ptr_inc[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  // Write FSM: state register
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) state <= ST_WR;
    else         state <= state_nxt;
  end

  // Write FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WR:   if (s_axis_tvalid && full && !s_axis_tlast) state_nxt = ST_DROP;
      ST_DROP: if (s_axis_tvalid && s_axis_tlast)          state_nxt = ST_WR;
      default: state_nxt = ST_WR;
    endcase
  end

  // Write FSM: decoded actions
  always_comb begin
    wr_en     = 1'b0;
    do_commit = 1'b0;
    do_rewind = 1'b0;
    inc_err   = 1'b0;
    inc_ovf   = 1'b0;
    if (state == ST_WR && s_axis_tvalid) begin
      if (full) begin
        do_rewind = 1'b1;
        inc_ovf   = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (s_axis_tlast && !s_axis_tuser) do_commit = 1'b1;
        if (s_axis_tlast && s_axis_tuser) begin
          do_rewind = 1'b1;
          inc_err   = 1'b1;
        end
      end
    end
  end

  // Write and commit pointers. A rewind throws away the uncommitted frame.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      if (do_rewind)  wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr_inc;
      if (do_commit) commit_ptr <= wr_ptr_inc;
    end
  end

  always_ff @(posedge clk156) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // FWFT read path: a RAM read register feeds the output register. Reads touch committed slots only.
  assign out_load = ram_vld && (!m_axis_tvalid || m_axis_tready);
  assign rd_en    = (commit_ptr != rd_ptr) && (!ram_vld || out_load);

  always_ff @(posedge clk156) begin
    if (rd_en) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      rd_ptr        <= '0;
      ram_vld       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      ram_vld <= rd_en || (ram_vld && !out_load);
      if (out_load) begin
        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram_q;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // Statistics: the forwarded-frame count wraps and the drop counts saturate.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      frame_cnt    <= '0;
      drop_err_cnt <= '0;
      drop_ovf_cnt <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_cnt <= frame_cnt + 32'd1;
      if (inc_err && drop_err_cnt != 16'hFFFF) drop_err_cnt <= drop_err_cnt + 16'd1;
      if (inc_ovf && drop_ovf_cnt != 16'hFFFF) drop_ovf_cnt <= drop_ovf_cnt + 16'd1;
    end
  end

endmodule
